// File: rtl/phase_mem_unit_pkg.sv
// Shared phase codes, FSM state codes and small phase helpers for the
// three-phase memory responder.
package phase_mem_unit_pkg;

   // One-hot strobe codes, bit order {internal, ram, cycle}, matching the generator.
   localparam logic [2:0] PH_CYCLE    = 3'b001;
   localparam logic [2:0] PH_RAM      = 3'b010;
   localparam logic [2:0] PH_INTERNAL = 3'b100;

   // Responder FSM state codes.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LATCHED = 2'd1;
   localparam logic [1:0] ST_RESP    = 2'd2;

   // Legal successor of a phase: cycle -> ram -> internal -> cycle.
   function automatic logic [2:0] next_phase(input logic [2:0] ph);
      return {ph[1:0], ph[2]};
   endfunction

   // High when two or more strobes are asserted together.
   function automatic logic multi_hot(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/phase_mem_unit_phase_checker.sv
// Strobe-order checker: tracks the last legal phase, flags illegal orders
// (wrong successor or several strobes at once) with a sticky error, and
// forwards a one-hot phase_ok only for legal strobes.
module phase_mem_unit_phase_checker
   import phase_mem_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       cycle_clk,
   input  logic       ram_clk,
   input  logic       internal_clk,
   output logic       phase_err,
   output logic       err_set,
   output logic [2:0] phase_ok
);

   logic [2:0] strobe_s;
   logic [2:0] last_phase_q;
   logic [2:0] last_phase_d;
   logic       err_q;
   logic       err_d;

   // Classify the current strobe set against the expected successor.
   always_comb begin
      strobe_s     = {internal_clk, ram_clk, cycle_clk};
      last_phase_d = last_phase_q;
      err_d        = err_q;
      err_set      = 1'b0;
      phase_ok     = 3'b000;
      if (err_q) begin
         // Sticky error: nothing advances until reset.
         last_phase_d = last_phase_q;
         phase_ok     = 3'b000;
      end else if (strobe_s == 3'b000) begin
         // Halt gap or between strobes: hold state.
         last_phase_d = last_phase_q;
      end else if (multi_hot(strobe_s) || (strobe_s != next_phase(last_phase_q))) begin
         err_d   = 1'b1;
         err_set = 1'b1;
      end else begin
         phase_ok     = strobe_s;
         last_phase_d = strobe_s;
      end
   end

   // Phase history and sticky error flag; reset makes cycle the next legal strobe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_phase_q <= PH_INTERNAL;
         err_q        <= 1'b0;
      end else begin
         last_phase_q <= last_phase_d;
         err_q        <= err_d;
      end
   end

   assign phase_err = err_q;

endmodule

// File: rtl/phase_mem_unit.sv
// Memory responder on the consuming end of the three-phase strobe set:
// latches a request on the cycle strobe, accesses the RAM on the ram strobe
// (after WAIT_STATES extra ram rounds), and responds on the internal strobe.
module phase_mem_unit
   import phase_mem_unit_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned WAIT_STATES = 0
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cycle_clk,
   input  logic              ram_clk,
   input  logic              internal_clk,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy,
   output logic              phase_err
);

   localparam int unsigned DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0]  WAIT_CMP = 4'(WAIT_STATES);

   logic [2:0]        phase_ok_s;
   logic              err_set_s;
   logic              mem_we_s;
   logic              rd_en_s;

   logic [1:0]        state_q,    state_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic              we_q,       we_d;
   logic [DATA_W-1:0] wdata_q,    wdata_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] rdata_q,    rdata_d;
   logic              rvalid_q,   rvalid_d;
   logic              busy_q,     busy_d;

   logic [DATA_W-1:0] mem [DEPTH];

   phase_mem_unit_phase_checker u_checker (
      .clk          (clk),
      .reset        (reset),
      .cycle_clk    (cycle_clk),
      .ram_clk      (ram_clk),
      .internal_clk (internal_clk),
      .phase_err    (phase_err),
      .err_set      (err_set_s),
      .phase_ok     (phase_ok_s)
   );

   // Request/access/response sequencing, advanced only by legal strobes.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      wait_cnt_d = wait_cnt_q;
      busy_d     = busy_q;
      rvalid_d   = 1'b0;
      mem_we_s   = 1'b0;
      rd_en_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (phase_ok_s[0] && req) begin
               state_d    = ST_LATCHED;
               addr_d     = addr;
               we_d       = we;
               wdata_d    = wdata;
               wait_cnt_d = 4'd0;
               busy_d     = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LATCHED: begin
            if (phase_ok_s[1]) begin
               if (wait_cnt_q == WAIT_CMP) begin
                  state_d = ST_RESP;
                  if (we_q) begin
                     mem_we_s = 1'b1;
                  end else begin
                     rd_en_s = 1'b1;
                  end
               end else begin
                  wait_cnt_d = wait_cnt_q + 4'd1;
               end
            end else begin
               state_d = ST_LATCHED;
            end
         end
         ST_RESP: begin
            if (phase_ok_s[2]) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b1;
               busy_d   = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // An illegal strobe aborts whatever is in flight.
      if (err_set_s) begin
         state_d    = ST_IDLE;
         busy_d     = 1'b0;
         rvalid_d   = 1'b0;
         wait_cnt_d = 4'd0;
         mem_we_s   = 1'b0;
         rd_en_s    = 1'b0;
      end else begin
         state_d = state_d;
      end

      if (rd_en_s) begin
         rdata_d = mem[addr_q];
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Control and output registers; reset cancels any access in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         wait_cnt_q <= 4'd0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         wait_cnt_q <= wait_cnt_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         busy_q     <= busy_d;
      end
   end

   // Memory array write port; contents survive reset, and no write commits during reset.
   always_ff @(posedge clk) begin
      if (reset && mem_we_s) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign busy   = busy_q;

endmodule
